// File: rtl/mc_control_pkg.sv
// mc_control shared definitions: state encodings, opcodes, ALU codes.
// Also consumed by the datapath and the bench.
package mc_control_pkg;

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_EXEC    = 4'd2;
   localparam logic [3:0] S_ALUWB   = 4'd3;
   localparam logic [3:0] S_MEMADR  = 4'd4;
   localparam logic [3:0] S_MEMRD   = 4'd5;
   localparam logic [3:0] S_MEMWB   = 4'd6;
   localparam logic [3:0] S_MEMWR   = 4'd7;
   localparam logic [3:0] S_BRANCH  = 4'd8;
   localparam logic [3:0] S_JUMP    = 4'd9;
   localparam logic [3:0] S_ADDI_EX = 4'd10;
   localparam logic [3:0] S_ADDI_WB = 4'd11;
   localparam logic [3:0] S_TRAP    = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JMP = 2'b10;

   // Opcode dispatch out of DECODE; unknown opcodes trap.
   function automatic logic [3:0] decode_op(logic [5:0] op);
      logic [3:0] s;
      case (op)
         OP_RTYPE:     s = S_EXEC;
         OP_LW, OP_SW: s = S_MEMADR;
         OP_BEQ:       s = S_BRANCH;
         OP_J:         s = S_JUMP;
         OP_ADDI:      s = S_ADDI_EX;
         default:      s = S_TRAP;
      endcase
      return s;
   endfunction

   // States that wait on mem_ready and are guarded by the timer.
   function automatic logic is_wait_state(logic [3:0] s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

   // Last state of an instruction before returning to FETCH.
   function automatic logic is_final_state(logic [3:0] s);
      return (s == S_ALUWB) || (s == S_MEMWB) || (s == S_MEMWR) ||
             (s == S_BRANCH) || (s == S_JUMP) || (s == S_ADDI_WB);
   endfunction

endpackage

// File: rtl/mc_control_wait_timer.sv
// mc_wait_timer: counts cycles spent waiting on mem_ready.
// expired_o fires on the wait cycle that brings the count to TIMEOUT.
module mc_wait_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam logic [8:0] LIMIT = 9'(TIMEOUT);

   logic [7:0] cnt_q, cnt_d;
   logic [8:0] cnt_inc;

   assign cnt_inc = {1'b0, cnt_q} + 9'd1;

   // A ready cycle never increments, so a late ready beats expiry.
   assign expired_o = inc_i && (cnt_inc == LIMIT);

   // Clear on state change, count while stalled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)      cnt_d = 8'd0;
      else if (inc_i) cnt_d = cnt_inc[7:0];
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= 8'd0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle sequencer for the MIPS-subset CPU.
// Define MC_CONTROL_PERF_CNT_EN to add cycle_cnt / instr_cnt outputs.
module mc_control
   import mc_control_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic       iord,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       ir_we,
   output logic       mdr_we,
   output logic       reg_we,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       trap,
   output logic [3:0] state_dbg
`ifdef MC_CONTROL_PERF_CNT_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
`endif
);

   logic [3:0] state_q, state_d;
   logic       tmr_clr, tmr_inc, expired;

   assign tmr_inc = is_wait_state(state_q) && !mem_ready;
   assign tmr_clr = (state_d != state_q);

   mc_wait_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (tmr_clr),
      .inc_i     (tmr_inc),
      .expired_o (expired)
   );

   // Next-state: step through the instruction phases.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:
            if (mem_ready)    state_d = S_DECODE;
            else if (expired) state_d = S_TRAP;
         S_DECODE:  state_d = decode_op(opcode);
         S_EXEC:    state_d = S_ALUWB;
         S_ALUWB:   state_d = S_FETCH;
         S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:
            if (mem_ready)    state_d = S_MEMWB;
            else if (expired) state_d = S_TRAP;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:
            if (mem_ready)    state_d = S_FETCH;
            else if (expired) state_d = S_TRAP;
         S_BRANCH:  state_d = S_FETCH;
         S_JUMP:    state_d = S_FETCH;
         S_ADDI_EX: state_d = S_ADDI_WB;
         S_ADDI_WB: state_d = S_FETCH;
         default:   state_d = S_TRAP;
      endcase
   end

   // State register; reset abandons any instruction in flight.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // Moore control decode; a few enables qualified by ready/zero.
   always_comb begin
      pc_we      = 1'b0;
      pc_src     = PCSRC_ALU;
      iord       = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      ir_we      = 1'b0;
      mdr_we     = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      alu_op     = ALU_ADD;
      trap       = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_rd    = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_we     = mem_ready;
            pc_we     = mem_ready;
         end
         S_DECODE: alu_src_b = SRCB_IMMSH2;
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            reg_we  = 1'b1;
            reg_dst = 1'b1;
         end
         S_MEMADR, S_ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            iord   = 1'b1;
            mem_rd = 1'b1;
            mdr_we = mem_ready;
         end
         S_MEMWB: begin
            reg_we     = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            iord   = 1'b1;
            mem_wr = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = PCSRC_BR;
            pc_we     = zero;
         end
         S_JUMP: begin
            pc_src = PCSRC_JMP;
            pc_we  = 1'b1;
         end
         S_ADDI_WB: reg_we = 1'b1;
         S_TRAP:    trap   = 1'b1;
         default:   trap   = 1'b1;
      endcase
      if (rst) begin
         pc_we  = 1'b0;
         ir_we  = 1'b0;
         mdr_we = 1'b0;
         reg_we = 1'b0;
         mem_rd = 1'b0;
         mem_wr = 1'b0;
      end
   end

   assign state_dbg = state_q;

`ifdef MC_CONTROL_PERF_CNT_EN
   logic [31:0] cyc_q, ins_q;

   // Cycle and retired-instruction counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q <= 32'd0;
         ins_q <= 32'd0;
      end else begin
         if (state_q != S_TRAP)
            cyc_q <= cyc_q + 32'd1;
         if (state_d == S_FETCH && is_final_state(state_q))
            ins_q <= ins_q + 32'd1;
      end
   end

   assign cycle_cnt = cyc_q;
   assign instr_cnt = ins_q;
`endif

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed + random instruction streams against
// an instruction-level phase model of the sequencer.
module tb_mc_control;
   import mc_control_pkg::*;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_we, iord, mem_rd, mem_wr, ir_we, mdr_we;
   logic       reg_we, reg_dst, mem_to_reg, alu_src_a, trap;
   logic [1:0] pc_src, alu_src_b, alu_op;
   logic [3:0] state_dbg;
`ifdef MC_CONTROL_PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt;
   logic [31:0] cyc_m = 32'd0;
   logic [31:0] ins_m = 32'd0;
`endif

   int tests = 0;
   int fails = 0;
   int ncyc = 0;
   logic [3:0] cur = S_FETCH;

   mc_control #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .iord       (iord),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .ir_we      (ir_we),
      .mdr_we     (mdr_we),
      .reg_we     (reg_we),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .trap       (trap),
      .state_dbg  (state_dbg)
`ifdef MC_CONTROL_PERF_CNT_EN
      ,
      .cycle_cnt  (cycle_cnt),
      .instr_cnt  (instr_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [16:0] ctrl_obs;
   assign ctrl_obs = {pc_we, pc_src, iord, mem_rd, mem_wr, ir_we,
                      mdr_we, reg_we, reg_dst, mem_to_reg, alu_src_a,
                      alu_src_b, alu_op, trap};

   // Control word required for a phase, straight from the state table.
   function automatic logic [16:0] exp_ctrl(logic [3:0] ph, logic rdy,
                                             logic z, logic r);
      logic pw, io, rd, wr, iw, mw, rw, rdst, m2r, a, tr;
      logic [1:0] ps, b, op;
      {pw, io, rd, wr, iw, mw, rw, rdst, m2r, a, tr} = '0;
      ps = 2'b00; b = 2'b00; op = 2'b00;
      case (ph)
         S_FETCH:   begin rd = 1; b = 2'b01; pw = rdy; iw = rdy; end
         S_DECODE:  b = 2'b11;
         S_EXEC:    begin a = 1; op = 2'b10; end
         S_ALUWB:   begin rw = 1; rdst = 1; end
         S_MEMADR:  begin a = 1; b = 2'b10; end
         S_MEMRD:   begin io = 1; rd = 1; mw = rdy; end
         S_MEMWB:   begin rw = 1; m2r = 1; end
         S_MEMWR:   begin io = 1; wr = 1; end
         S_BRANCH:  begin a = 1; op = 2'b01; ps = 2'b01; pw = z; end
         S_JUMP:    begin ps = 2'b10; pw = 1; end
         S_ADDI_EX: begin a = 1; b = 2'b10; end
         S_ADDI_WB: rw = 1;
         default:   tr = 1;
      endcase
      if (r) {pw, iw, mw, rw, rd, wr} = '0;
      return {pw, ps, io, rd, wr, iw, mw, rw, rdst, m2r, a, b, op, tr};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check at negedge, move past posedge.
   task automatic step(input logic [3:0] ph, input logic rdy,
                       input logic z);
      mem_ready = rdy;
      zero = z;
      @(negedge clk);
      chk($sformatf("state@%0d", ncyc), 32'(state_dbg), 32'(ph));
      chk($sformatf("ctrl@%0d st%0d", ncyc, ph), 32'(ctrl_obs),
          32'(exp_ctrl(ph, rdy, z, rst)));
`ifdef MC_CONTROL_PERF_CNT_EN
      chk("cycle_cnt", cycle_cnt, cyc_m);
      chk("instr_cnt", instr_cnt, ins_m);
      if (rst) begin
         cyc_m = 32'd0;
         ins_m = 32'd0;
      end else if (ph != S_TRAP) begin
         cyc_m = cyc_m + 32'd1;
      end
`endif
      ncyc++;
      @(posedge clk);
      #1;
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Memory wait: ready after dly low cycles, trap after TO low cycles.
   task automatic wait_phase(input logic [3:0] ph, input int dly,
                             input logic z, output bit trapped,
                             output int waits);
      bit done;
      logic rdy;
      done = 0;
      trapped = 0;
      waits = 0;
      while (!done) begin
         rdy = (waits >= dly);
         step(ph, rdy, z);
         if (rdy) begin
            done = 1;
         end else begin
            waits++;
            if (waits == TO) begin
               trapped = 1;
               done = 1;
            end
         end
      end
   endtask

   task automatic run_instr(input logic [5:0] op, input logic z,
                            input int fd, input int md,
                            output int cycles, output bit trapped,
                            output int mwaits);
      int start, w;
      start = ncyc;
      opcode = op;
      mwaits = 0;
      wait_phase(S_FETCH, fd, z, trapped, w);
      if (!trapped) begin
         step(S_DECODE, rb(), z);
         case (op)
            OP_RTYPE: begin
               step(S_EXEC, rb(), z);
               step(S_ALUWB, rb(), z);
            end
            OP_LW: begin
               step(S_MEMADR, rb(), z);
               wait_phase(S_MEMRD, md, z, trapped, mwaits);
               if (!trapped) step(S_MEMWB, rb(), z);
            end
            OP_SW: begin
               step(S_MEMADR, rb(), z);
               wait_phase(S_MEMWR, md, z, trapped, mwaits);
            end
            OP_BEQ: step(S_BRANCH, rb(), z);
            OP_J:   step(S_JUMP, rb(), z);
            OP_ADDI: begin
               step(S_ADDI_EX, rb(), z);
               step(S_ADDI_WB, rb(), z);
            end
            default: trapped = 1;
         endcase
      end
      cycles = ncyc - start;
      cur = trapped ? S_TRAP : S_FETCH;
`ifdef MC_CONTROL_PERF_CNT_EN
      if (!trapped) ins_m = ins_m + 32'd1;
`endif
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++)
         step((i == 0) ? cur : S_FETCH, rb(), rb());
      rst = 1'b0;
      cur = S_FETCH;
   endtask

   task automatic trap_hold(input int n);
      for (int i = 0; i < n; i++) step(S_TRAP, rb(), rb());
   endtask

   function automatic int pick_delay();
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) return TO;
      if (r == 1) return TO - 1;
      return $urandom_range(0, 3);
   endfunction

   initial begin
      int  cyc, mw;
      bit  tr;
      logic [5:0] ops [8];
      ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_LW, 6'h3f};

      repeat (2) @(posedge clk);
      #1;
      do_reset(2);

      // Reset held three cycles in the middle of a load.
      opcode = OP_LW;
      step(S_FETCH, 1'b1, 1'b0);
      step(S_DECODE, 1'b0, 1'b0);
      step(S_MEMADR, 1'b0, 1'b0);
      step(S_MEMRD, 1'b0, 1'b0);
      cur = S_MEMRD;
      do_reset(3);

      run_instr(OP_RTYPE, 1'b0, 0, 0, cyc, tr, mw);
      chk("lat_rtype", 32'(cyc), 32'd4);
      run_instr(OP_LW, 1'b0, 0, 3, cyc, tr, mw);
      chk("lat_lw_wait3", 32'(cyc), 32'd8);
      run_instr(OP_LW, 1'b1, 0, 0, cyc, tr, mw);
      chk("lat_lw", 32'(cyc), 32'd5);
      run_instr(OP_SW, 1'b0, 0, 0, cyc, tr, mw);
      chk("lat_sw", 32'(cyc), 32'd4);
      run_instr(OP_BEQ, 1'b1, 0, 0, cyc, tr, mw);
      chk("lat_beq_taken", 32'(cyc), 32'd3);
      run_instr(OP_BEQ, 1'b0, 0, 0, cyc, tr, mw);
      chk("lat_beq_not", 32'(cyc), 32'd3);
      run_instr(OP_J, 1'b0, 0, 0, cyc, tr, mw);
      chk("lat_j", 32'(cyc), 32'd3);
      run_instr(OP_ADDI, 1'b0, 0, 0, cyc, tr, mw);
      chk("lat_addi", 32'(cyc), 32'd4);
      run_instr(OP_SW, 1'b0, 0, TO - 1, cyc, tr, mw);
      chk("late_ready_wins", 32'(tr), 32'd0);

      // Illegal opcode traps and stays trapped until reset.
      run_instr(6'h3f, 1'b0, 0, 0, cyc, tr, mw);
      chk("illegal_trap", 32'(tr), 32'd1);
      trap_hold(20);
      do_reset(2);

      // Store that never completes.
      run_instr(OP_SW, 1'b0, 0, 1000, cyc, tr, mw);
      chk("sw_timeout_trap", 32'(tr), 32'd1);
      chk("sw_timeout_waits", 32'(mw), 32'(TO));
      trap_hold(3);
      do_reset(1);

      // Random instruction stream.
      for (int i = 0; i < 150; i++) begin
         run_instr(ops[$urandom_range(0, 7)], rb(), pick_delay(),
                   pick_delay(), cyc, tr, mw);
         if (tr) begin
            trap_hold($urandom_range(1, 4));
            do_reset($urandom_range(1, 3));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
